cia_eclk_bus: RTL and testbench

Synchronous 6800-style peripheral bus sequencer for CIA accesses. It consumes the 7 MHz clock enable and the 10-phase one-hot E-clock vector produced by the Amiga clock generator. It aligns CPU-side CIA requests to the E-clock, drives VMA and an E-level signal, and issues a single-cycle strobe to the CIA at the E falling edge. It sits between the CPU bus decode and the CIA pair, all in the clk_28 domain.

---
 rtl/cia_eclk_bus.sv | 136 +++++++++++++
 tb/tb_cia_eclk_bus.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cia_eclk_bus.sv
// cia_eclk_bus: aligns CIA requests to the E-clock and drives VMA, E and a one-cycle CIA strobe at phase 9.
// Latency: VMA 1..10 ticks after acceptance, strobe (9-VMA_PHASE) ticks after VMA, all outputs registered.
// Backpressure: req/ack level handshake; with CIA_ECLK_ABORT_EN a dropped req cancels the access before its strobe.
module cia_eclk_bus #(
  parameter int E_HIGH_FIRST = 6,
  parameter int VMA_PHASE    = 3
) (
  input  logic       clk_28,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic [9:0] eclk,
  input  logic       req,
  input  logic       rd_wn,
  input  logic [7:0] cpu_din,
  input  logic [7:0] cia_dout,
  output logic [7:0] cia_din,
  output logic       cia_rd_wn,
  output logic       vma,
  output logic       e_level,
  output logic       cia_strobe,
  output logic [7:0] rdata,
  output logic       ack,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    ACTIVE    = 2'd2,
    ACK       = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic       tick;
  logic       phase_ok;
  logic       vma_match;
  logic       end_match;
  logic       abort;
  logic       vma_nxt;
  logic       ack_nxt;
  logic       strobe_nxt;
  logic       rd_wn_nxt;
  logic       busy_nxt;
  logic [7:0] din_nxt;
  logic [7:0] rdata_nxt;

  assign tick = clk7_en;

  // A glitched (all-zero or multi-hot) phase vector must never produce a match.
  assign phase_ok  = (eclk != 10'd0) && ((eclk & (eclk - 10'd1)) == 10'd0);
  assign vma_match = tick && phase_ok && eclk[VMA_PHASE];
  assign end_match = tick && phase_ok && eclk[9];

`ifdef CIA_ECLK_ABORT_EN
  assign abort = !req;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    vma_nxt    = vma;
    ack_nxt    = ack;
    strobe_nxt = 1'b0;
    rd_wn_nxt  = cia_rd_wn;
    din_nxt    = cia_din;
    rdata_nxt  = rdata;
    case (state)
      IDLE: begin
        if (tick && req) begin
          rd_wn_nxt = rd_wn;
          din_nxt   = cpu_din;
          state_nxt = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (vma_match) begin
          vma_nxt   = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (abort) begin
          vma_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (end_match) begin
          strobe_nxt = 1'b1;
          vma_nxt    = 1'b0;
          ack_nxt    = 1'b1;
          state_nxt  = ACK;
          if (cia_rd_wn) begin
            rdata_nxt = cia_dout;
          end
        end
      end
      ACK: begin
        // Release is not tick-aligned so the CPU sees ack drop promptly.
        if (!req) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      vma        <= 1'b0;
      e_level    <= 1'b0;
      cia_strobe <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      rdata      <= 8'h00;
      cia_din    <= 8'h00;
      cia_rd_wn  <= 1'b1;
    end else begin
      state      <= state_nxt;
      vma        <= vma_nxt;
      e_level    <= |eclk[9:E_HIGH_FIRST];
      cia_strobe <= strobe_nxt;
      ack        <= ack_nxt;
      busy       <= busy_nxt;
      rdata      <= rdata_nxt;
      cia_din    <= din_nxt;
      cia_rd_wn  <= rd_wn_nxt;
    end
  end

endmodule

// File: tb/tb_cia_eclk_bus.sv
// tb_cia_eclk_bus: drives a free-running 7 MHz tick and rotating E phase, issues CIA accesses and
// predicts VMA/strobe/ack timing from the phase arithmetic of the bus protocol.
module tb_cia_eclk_bus;
  localparam int EH = 6;
  localparam int VP = 3;

  logic       clk_28;
  logic       reset_n;
  logic       clk7_en;
  logic [9:0] eclk;
  logic [9:0] eclk_oh;
  logic [9:0] eclk_ovr;
  logic       eclk_ovr_en;
  logic       req;
  logic       rd_wn;
  logic [7:0] cpu_din;
  logic [7:0] cia_dout;
  logic [7:0] cia_din;
  logic       cia_rd_wn;
  logic       vma;
  logic       e_level;
  logic       cia_strobe;
  logic [7:0] rdata;
  logic       ack;
  logic       busy;

  int         n_tests = 0;
  int         n_fail = 0;
  int         ph;
  int         div;
  logic       last_tick;
  int         last_ph;
  logic [9:0] last_eclk;
  logic [7:0] exp_rdata;

  cia_eclk_bus #(.E_HIGH_FIRST(EH), .VMA_PHASE(VP)) dut (
    .clk_28     (clk_28),
    .reset_n    (reset_n),
    .clk7_en    (clk7_en),
    .eclk       (eclk),
    .req        (req),
    .rd_wn      (rd_wn),
    .cpu_din    (cpu_din),
    .cia_dout   (cia_dout),
    .cia_din    (cia_din),
    .cia_rd_wn  (cia_rd_wn),
    .vma        (vma),
    .e_level    (e_level),
    .cia_strobe (cia_strobe),
    .rdata      (rdata),
    .ack        (ack),
    .busy       (busy)
  );

  initial clk_28 = 1'b0;
  always #5 clk_28 = ~clk_28;

  assign eclk = eclk_ovr_en ? eclk_ovr : eclk_oh;

  // One tick every 4 clk_28 cycles; the E phase advances after each tick.
  initial begin
    ph      = 0;
    div     = 0;
    clk7_en = 1'b0;
    eclk_oh = 10'd1;
    forever begin
      @(negedge clk_28);
      if (clk7_en) ph = (ph + 1) % 10;
      div     = (div + 1) % 4;
      clk7_en = (div == 0);
      eclk_oh = 10'd1 << ph;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h, expected %02h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // E is high whenever some active phase bit lies in the range EH..9.
  function automatic logic e_high(input logic [9:0] v);
    logic r;
    r = 1'b0;
    for (int i = EH; i < 10; i++) r = r | v[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk_28);
    last_tick = clk7_en;
    last_ph   = ph;
    last_eclk = eclk;
    @(negedge clk_28);
    #1;
    if (reset_n) check1("e_level", e_level, e_high(last_eclk));
    else         check1("e_level_rst", e_level, 1'b0);
  endtask

  // mode 0: normal, 1: invalid eclk while waiting, 2: req dropped in ACTIVE, 3: reset in ACTIVE
  task automatic txn(input int p, input logic rd, input logic [7:0] wd, input logic [7:0] cd, input int mode);
    int   k, ticks, vma_t, guard, nstb;
    logic stop, prev_vma, got_strobe;
    guard = 0;
    while (!(clk7_en && ph == p) && guard < 60) begin
      step();
      guard++;
    end
    check1("align", guard < 60, 1'b1);
    req = 1'b1; rd_wn = rd; cpu_din = wd; cia_dout = cd;
    step();
    check1("accept_busy", busy, 1'b1);
    check1("accept_dir", cia_rd_wn, rd);
    check8("accept_din", cia_din, wd);
    rd_wn = ~rd; cpu_din = ~wd;
    k = (VP - p + 10) % 10;
    if (k == 0) k = 10;
    ticks = 0; vma_t = -1; nstb = 0; stop = 1'b0; prev_vma = 1'b0; got_strobe = 1'b0;
    if (mode == 1) begin
      eclk_ovr = 10'd0;
      eclk_ovr_en = 1'b1;
    end
    for (int c = 0; c < 400 && !stop; c++) begin
      step();
      if (last_tick) ticks++;
      if (mode == 1) begin
        if (ticks < 20) begin
          check1("no_vma_bad_eclk", vma, 1'b0);
          check1("busy_bad_eclk", busy, 1'b1);
        end
        if (ticks == 10) eclk_ovr = 10'b10_0000_1000;
        if (ticks >= 20) eclk_ovr_en = 1'b0;
      end
      check8("din_stable", cia_din, wd);
      check1("dir_stable", cia_rd_wn, rd);
      if (vma && !prev_vma) begin
        vma_t = ticks;
        checki("vma_phase", last_ph, VP);
        check1("vma_on_tick", last_tick, 1'b1);
        if (mode == 1) check1("vma_after_restore", ticks > 20, 1'b1);
        else           checki("vma_latency", ticks, k);
        if (mode == 2) begin
          req = 1'b0;
`ifdef CIA_ECLK_ABORT_EN
          step();
          check1("abort_vma", vma, 1'b0);
          check1("abort_busy", busy, 1'b0);
          check1("abort_ack", ack, 1'b0);
          for (int i = 0; i < 50; i++) begin
            step();
            if (cia_strobe) nstb++;
          end
          checki("abort_no_strobe", nstb, 0);
          stop = 1'b1;
`endif
        end
        if (mode == 3) begin
          step();
          step();
          #2;
          reset_n = 1'b0;
          #1;
          check1("rst_vma", vma, 1'b0);
          check1("rst_ack", ack, 1'b0);
          check1("rst_busy", busy, 1'b0);
          check1("rst_strobe", cia_strobe, 1'b0);
          for (int i = 0; i < 40; i++) begin
            step();
            if (cia_strobe) nstb++;
          end
          checki("rst_no_strobe", nstb, 0);
          check8("rst_rdata", rdata, 8'h00);
          check8("rst_din", cia_din, 8'h00);
          check1("rst_dir", cia_rd_wn, 1'b1);
          req = 1'b0;
          reset_n = 1'b1;
          exp_rdata = 8'h00;
          stop = 1'b1;
        end
      end
      prev_vma = vma;
      if (!stop && cia_strobe) begin
        got_strobe = 1'b1;
        check1("strobe_vma_low", vma, 1'b0);
        check1("strobe_ack", ack, 1'b1);
        check1("strobe_on_tick", last_tick, 1'b1);
        checki("strobe_phase", last_ph, 9);
        checki("vma_to_strobe", ticks - vma_t, 9 - VP);
        if (rd) exp_rdata = cd;
        check8("rdata", rdata, exp_rdata);
        stop = 1'b1;
      end
    end
    check1("txn_done", stop, 1'b1);
    if (got_strobe) begin
      step();
      check1("strobe_one_cycle", cia_strobe, 1'b0);
      if (mode == 2) begin
        check1("ack_clear_drop", ack, 1'b0);
        check1("idle_drop", busy, 1'b0);
      end else begin
        for (int i = 0; i < 3; i++) begin
          check1("ack_hold", ack, 1'b1);
          step();
        end
        req = 1'b0;
        step();
        check1("ack_clear", ack, 1'b0);
        check1("idle_after", busy, 1'b0);
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    req         = 1'b0;
    rd_wn       = 1'b0;
    cpu_din     = 8'h00;
    cia_dout    = 8'h00;
    eclk_ovr    = 10'd0;
    eclk_ovr_en = 1'b0;
    exp_rdata   = 8'h00;
    repeat (3) @(negedge clk_28);
    #1;
    check1("reset_vma", vma, 1'b0);
    check1("reset_e_level", e_level, 1'b0);
    check1("reset_strobe", cia_strobe, 1'b0);
    check1("reset_ack", ack, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check8("reset_rdata", rdata, 8'h00);
    check8("reset_din", cia_din, 8'h00);
    check1("reset_dir", cia_rd_wn, 1'b1);
    reset_n = 1'b1;

    txn(4, 1'b1, 8'($urandom), 8'hA5, 0);
    txn(2, 1'b0, 8'h3C, 8'($urandom), 0);
    txn(3, 1'b1, 8'($urandom), 8'($urandom), 0);
    txn(4, 1'b1, 8'($urandom), 8'($urandom), 1);
    txn(5, 1'b1, 8'($urandom), 8'($urandom), 3);
    txn(6, 1'b1, 8'($urandom), 8'($urandom), 2);
    for (int n = 0; n < 8; n++) begin
      txn(int'($urandom_range(0, 9)), 1'($urandom), 8'($urandom), 8'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
